pipe_hazard_ctrl: RTL and testbench

- Parametrised pipeline-control block for the next-generation CPU pipeline.
- Tracks every instruction issued past decode (valid, destination register, write-back enable, load flag) through STAGES back-end stages (stage 1 = EX ... stage STAGES = WB).
- Detects read-after-write hazards for the instruction in ID and either stalls decode or generates EX-stage forwarding selects.
- Also handles external memory wait, flush, and hazard-stall statistics.

---
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Back-end pipeline tracker with RAW hazard detection, decode stall and EX forwarding selects.
// Optional macro HAZARD_FWD_EN enables forwarding; without it every in-flight RAW match stalls.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_READY = 3,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_a_reg,
  input  logic [REG_W-1:0]  id_b_reg,
  input  logic              id_a_used,
  input  logic              id_b_used,
  input  logic              id_wb_en,
  input  logic [REG_W-1:0]  id_wb_reg,
  input  logic              id_is_load,
  input  logic              ext_stall,
  input  logic              flush,
  output logic              stall_id,
  output logic [SEL_W-1:0]  ex_fwd_a_sel,
  output logic [SEL_W-1:0]  ex_fwd_b_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic [CNT_W-1:0]  stall_cnt
);

`ifdef HAZARD_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  // Per-stage entry, index k holds stage k+1 (index 0 = EX, STAGES-1 = WB).
  logic [STAGES-1:0]            vld_pk;
  logic [STAGES-1:0]            wbe_pk;
  logic [STAGES-1:0][REG_W-1:0] dst_pk;
  // The WB entry is never compared, so its load flag is not kept.
  logic [STAGES-2:0]            ld_pk;

  logic [SEL_W-1:0] sel_a_p1, sel_b_p1;
  logic [CNT_W-1:0] cnt_q;

  logic             hit_a, hit_b, load_a, load_b;
  logic [SEL_W-1:0] stg_a, stg_b;
  logic             stall_a, stall_b;
  logic [SEL_W-1:0] sel_a_p0, sel_b_p0;
  logic             hazard, stall_hz, accept;

  function automatic logic needs_stall(input logic hit, input logic load,
                                       input logic [SEL_W-1:0] stg);
    needs_stall = hit && (!FWD_EN || (load && (int'(stg) + 1 < LOAD_READY)));
  endfunction

  function automatic logic [SEL_W-1:0] fwd_sel(input logic hit, input logic stall,
                                               input logic [SEL_W-1:0] stg);
    fwd_sel = (hit && !stall) ? stg + SEL_W'(1) : '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    sat_inc = (&c) ? c : c + CNT_W'(1);
  endfunction

  // ---- ID stage: compare sources against stages 1..STAGES-1 ----
  // Scan from oldest to youngest so the youngest matching producer wins.
  always_comb begin
    hit_a  = 1'b0;
    hit_b  = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    stg_a  = '0;
    stg_b  = '0;
    for (int k = STAGES - 2; k >= 0; k--) begin
      if (id_a_used && (id_a_reg != '0) && vld_pk[k] && wbe_pk[k] && (dst_pk[k] == id_a_reg)) begin
        hit_a  = 1'b1;
        load_a = ld_pk[k];
        stg_a  = SEL_W'(k + 1);
      end
      if (id_b_used && (id_b_reg != '0) && vld_pk[k] && wbe_pk[k] && (dst_pk[k] == id_b_reg)) begin
        hit_b  = 1'b1;
        load_b = ld_pk[k];
        stg_b  = SEL_W'(k + 1);
      end
    end
  end

  // The producer advances one stage by the time the consumer reaches EX, hence stage+1.
  assign stall_a  = needs_stall(hit_a, load_a, stg_a);
  assign stall_b  = needs_stall(hit_b, load_b, stg_b);
  assign sel_a_p0 = fwd_sel(hit_a, stall_a, stg_a);
  assign sel_b_p0 = fwd_sel(hit_b, stall_b, stg_b);

  assign hazard   = id_valid && (stall_a || stall_b);
  assign stall_hz = hazard && !flush;
  assign accept   = id_valid && !flush && !hazard;
  assign stall_id = stall_hz || ext_stall;

  // ---- ID -> EX boundary and back-end shift ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pk   <= '0;
      wbe_pk   <= '0;
      dst_pk   <= '0;
      ld_pk    <= '0;
      sel_a_p1 <= '0;
      sel_b_p1 <= '0;
      cnt_q    <= '0;
    end else if (!ext_stall) begin
      for (int k = STAGES - 1; k > 0; k--) begin
        vld_pk[k] <= vld_pk[k-1];
        wbe_pk[k] <= wbe_pk[k-1];
        dst_pk[k] <= dst_pk[k-1];
      end
      for (int k = STAGES - 2; k > 0; k--) begin
        ld_pk[k] <= ld_pk[k-1];
      end
      vld_pk[0] <= accept;
      wbe_pk[0] <= accept && id_wb_en;
      dst_pk[0] <= accept ? id_wb_reg : '0;
      ld_pk[0]  <= accept && id_is_load;
      sel_a_p1  <= accept ? sel_a_p0 : '0;
      sel_b_p1  <= accept ? sel_b_p0 : '0;
      if (stall_hz) begin
        cnt_q <= sat_inc(cnt_q);
      end
    end
  end

  // ---- WB stage outputs ----
  assign ex_fwd_a_sel = sel_a_p1;
  assign ex_fwd_b_sel = sel_b_p1;
  assign stage_valid  = vld_pk;
  assign wb_en        = vld_pk[STAGES-1] && wbe_pk[STAGES-1];
  assign wb_reg       = dst_pk[STAGES-1];
  assign stall_cnt    = cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl (STAGES=3, LOAD_READY=3, CNT_W=3 for saturation).
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct packed {
    logic       v;
    logic [4:0] a;
    logic       au;
    logic [4:0] b;
    logic       bu;
    logic       wbe;
    logic [4:0] wbr;
    logic       ld;
    logic       xs;
    logic       fl;
  } stim_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] sv;
    logic [2:0] cnt;
  } exp_t;

  localparam stim_t NOP = '0;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_a_used, id_b_used, id_wb_en, id_is_load, ext_stall, flush;
  logic [4:0] id_a_reg, id_b_reg, id_wb_reg;
  logic       stall_id, wb_en;
  logic [1:0] ex_fwd_a_sel, ex_fwd_b_sel;
  logic [2:0] stage_valid;
  logic [4:0] wb_reg;
  logic [2:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  stim_t st_q[$];
  exp_t  et_q[$];
  exp_t  sb[$];

  pipe_hazard_ctrl #(.STAGES(3), .REG_W(5), .LOAD_READY(3), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_a_reg(id_a_reg), .id_b_reg(id_b_reg),
    .id_a_used(id_a_used), .id_b_used(id_b_used), .id_wb_en(id_wb_en), .id_wb_reg(id_wb_reg),
    .id_is_load(id_is_load), .ext_stall(ext_stall), .flush(flush), .stall_id(stall_id),
    .ex_fwd_a_sel(ex_fwd_a_sel), .ex_fwd_b_sel(ex_fwd_b_sel), .stage_valid(stage_valid),
    .wb_en(wb_en), .wb_reg(wb_reg), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic stim_t ins(input int a, input int au, input int b, input int bu,
                                input int wbe, input int wbr, input int ld);
    stim_t s;
    s     = '0;
    s.v   = 1'b1;
    s.a   = 5'(a);
    s.au  = 1'(au);
    s.b   = 5'(b);
    s.bu  = 1'(bu);
    s.wbe = 1'(wbe);
    s.wbr = 5'(wbr);
    s.ld  = 1'(ld);
    return s;
  endfunction

  function automatic stim_t xf(input stim_t s, input int xs, input int fl);
    stim_t r;
    r    = s;
    r.xs = 1'(xs);
    r.fl = 1'(fl);
    return r;
  endfunction

  function automatic exp_t E(input int st, input int sa, input int sbv, input int sv, input int cnt);
    exp_t e;
    e.stall = 1'(st);
    e.sa    = 2'(sa);
    e.sb    = 2'(sbv);
    e.sv    = 3'(sv);
    e.cnt   = 3'(cnt);
    return e;
  endfunction

  function automatic exp_t obs();
    exp_t e;
    e.stall = stall_id;
    e.sa    = ex_fwd_a_sel;
    e.sb    = ex_fwd_b_sel;
    e.sv    = stage_valid;
    e.cnt   = stall_cnt;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid   = s.v;
    id_a_reg   = s.a;
    id_a_used  = s.au;
    id_b_reg   = s.b;
    id_b_used  = s.bu;
    id_wb_en   = s.wbe;
    id_wb_reg  = s.wbr;
    id_is_load = s.ld;
    ext_stall  = s.xs;
    flush      = s.fl;
  endtask

  task automatic add(input stim_t s, input exp_t e);
    st_q.push_back(s);
    et_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(NOP);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1;
    drive(NOP);
    #1;
    got = obs();
    checks++;
    if (got !== E(0, 0, 0, 0, 0)) begin
      failures++;
      $display("FAIL reset_state: got %p want all zero", got);
    end
    checks++;
    if ({wb_en, wb_reg} !== 6'd0) begin
      failures++;
      $display("FAIL reset_wb: got wb_en=%0b wb_reg=%0d want 0/0", wb_en, wb_reg);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_raw();
    stim_t p5, c5;
    exp_t  got, want;
    p5 = ins(1, 1, 2, 1, 1, 5, 0);
    c5 = ins(5, 1, 5, 1, 1, 6, 0);
    st_q.delete();
    et_q.delete();
    if (FWD) begin
      add(p5,  E(0, 0, 0, 3'b000, 0));
      add(c5,  E(0, 0, 0, 3'b001, 0));
      add(NOP, E(0, 2, 2, 3'b011, 0));
      add(NOP, E(0, 0, 0, 3'b110, 0));
      add(NOP, E(0, 0, 0, 3'b100, 0));
      add(p5,  E(0, 0, 0, 3'b000, 0));
      add(NOP, E(0, 0, 0, 3'b001, 0));
      add(c5,  E(0, 0, 0, 3'b010, 0));
      add(NOP, E(0, 3, 3, 3'b101, 0));
      add(NOP, E(0, 0, 0, 3'b010, 0));
    end else begin
      add(p5,  E(0, 0, 0, 3'b000, 0));
      add(c5,  E(1, 0, 0, 3'b001, 0));
      add(c5,  E(1, 0, 0, 3'b010, 1));
      add(c5,  E(0, 0, 0, 3'b100, 2));
      add(NOP, E(0, 0, 0, 3'b001, 2));
      add(NOP, E(0, 0, 0, 3'b010, 2));
      add(NOP, E(0, 0, 0, 3'b100, 2));
      add(p5,  E(0, 0, 0, 3'b000, 2));
      add(NOP, E(0, 0, 0, 3'b001, 2));
      add(c5,  E(1, 0, 0, 3'b010, 2));
      add(c5,  E(0, 0, 0, 3'b100, 3));
      add(NOP, E(0, 0, 0, 3'b001, 3));
    end
    do_reset();
    for (int i = 0; i < st_q.size(); i++) begin
      drive(st_q[i]);
      sb.push_back(et_q[i]);
      @(negedge clk);
      got  = obs();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL alu_raw cyc%0d: got %p want %p", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_use();
    stim_t lw, cu;
    exp_t  got, want;
    lw = ins(1, 1, 0, 0, 1, 7, 1);
    cu = ins(7, 1, 0, 1, 1, 8, 0);
    st_q.delete();
    et_q.delete();
    if (FWD) begin
      add(lw,  E(0, 0, 0, 3'b000, 0));
      add(cu,  E(1, 0, 0, 3'b001, 0));
      add(cu,  E(0, 0, 0, 3'b010, 1));
      add(NOP, E(0, 3, 0, 3'b101, 1));
      add(NOP, E(0, 0, 0, 3'b010, 1));
    end else begin
      add(lw,  E(0, 0, 0, 3'b000, 0));
      add(cu,  E(1, 0, 0, 3'b001, 0));
      add(cu,  E(1, 0, 0, 3'b010, 1));
      add(cu,  E(0, 0, 0, 3'b100, 2));
      add(NOP, E(0, 0, 0, 3'b001, 2));
    end
    do_reset();
    for (int i = 0; i < st_q.size(); i++) begin
      drive(st_q[i]);
      sb.push_back(et_q[i]);
      @(negedge clk);
      got  = obs();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL load_use cyc%0d: got %p want %p", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_r0_priority();
    stim_t p0, cr0, w1, w2, cn;
    exp_t  got, want;
    p0  = ins(1, 1, 2, 1, 1, 0, 0);
    cr0 = ins(0, 1, 0, 1, 1, 13, 0);
    w1  = ins(3, 0, 4, 0, 1, 9, 0);
    w2  = ins(3, 0, 4, 0, 1, 9, 0);
    cn  = ins(9, 1, 9, 0, 1, 12, 0);
    st_q.delete();
    et_q.delete();
    add(p0,  E(0, 0, 0, 3'b000, 0));
    add(cr0, E(0, 0, 0, 3'b001, 0));
    add(NOP, E(0, 0, 0, 3'b011, 0));
    add(w1,  E(0, 0, 0, 3'b110, 0));
    add(w2,  E(0, 0, 0, 3'b101, 0));
    if (FWD) begin
      add(cn,  E(0, 0, 0, 3'b011, 0));
      add(NOP, E(0, 2, 0, 3'b111, 0));
      add(NOP, E(0, 0, 0, 3'b110, 0));
    end else begin
      add(cn,  E(1, 0, 0, 3'b011, 0));
      add(cn,  E(1, 0, 0, 3'b110, 1));
      add(cn,  E(0, 0, 0, 3'b100, 2));
      add(NOP, E(0, 0, 0, 3'b001, 2));
    end
    do_reset();
    for (int i = 0; i < st_q.size(); i++) begin
      drive(st_q[i]);
      sb.push_back(et_q[i]);
      @(negedge clk);
      got  = obs();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL r0_priority cyc%0d: got %p want %p", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ext_stall_flush();
    stim_t lw, cu;
    exp_t  got, want;
    lw = ins(1, 1, 0, 0, 1, 7, 1);
    cu = ins(7, 1, 0, 1, 1, 8, 0);
    st_q.delete();
    et_q.delete();
    add(lw,             E(0, 0, 0, 3'b000, 0));
    add(xf(cu, 1, 0),   E(1, 0, 0, 3'b001, 0));
    add(xf(cu, 1, 0),   E(1, 0, 0, 3'b001, 0));
    add(xf(cu, 1, 1),   E(1, 0, 0, 3'b001, 0));
    add(xf(cu, 1, 0),   E(1, 0, 0, 3'b001, 0));
    add(xf(cu, 0, 1),   E(0, 0, 0, 3'b001, 0));
    add(NOP,            E(0, 0, 0, 3'b010, 0));
    add(NOP,            E(0, 0, 0, 3'b100, 0));
    add(NOP,            E(0, 0, 0, 3'b000, 0));
    do_reset();
    for (int i = 0; i < st_q.size(); i++) begin
      drive(st_q[i]);
      sb.push_back(et_q[i]);
      @(negedge clk);
      got  = obs();
      want = sb.pop_front();
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ext_stall_flush cyc%0d: got %p want %p", i, got, want);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_saturation();
    stim_t lw, cu;
    int    spp, want;
    lw  = ins(1, 1, 0, 0, 1, 7, 1);
    cu  = ins(7, 1, 0, 1, 1, 8, 0);
    spp = FWD ? 1 : 2;
    do_reset();
    for (int p = 1; p <= 9; p++) begin
      drive(lw);
      @(posedge clk);
      #1;
      for (int s = 0; s <= spp; s++) begin
        drive(cu);
        @(negedge clk);
        checks++;
        if (stall_id !== (s < spp)) begin
          failures++;
          $display("FAIL sat_stall pair%0d cyc%0d: got %0b want %0b", p, s, stall_id, (s < spp));
        end
        @(posedge clk);
        #1;
      end
      // stall_cnt as seen in the consumer's accept cycle
      want = (p * spp > 7) ? 7 : p * spp;
      checks++;
      if (stall_cnt !== 3'(want)) begin
        failures++;
        $display("FAIL sat_count pair%0d: got %0d want %0d", p, stall_cnt, want);
      end
    end
    drive(NOP);
  endtask

  task automatic test_reset_mid_run();
    stim_t lw, cu, i1, i2;
    int    spp;
    lw  = ins(1, 1, 0, 0, 1, 7, 1);
    cu  = ins(7, 1, 0, 1, 1, 8, 0);
    i1  = ins(0, 0, 0, 0, 1, 10, 0);
    i2  = ins(0, 0, 0, 0, 1, 11, 0);
    spp = FWD ? 1 : 2;
    do_reset();
    drive(lw);
    @(posedge clk);
    #1;
    drive(cu);
    repeat (spp + 1) begin
      @(posedge clk);
      #1;
    end
    drive(i1);
    @(posedge clk);
    #1;
    drive(i2);
    @(posedge clk);
    #1;
    drive(NOP);
    #2;
    checks++;
    if ({stage_valid, wb_en, wb_reg, stall_cnt} !== {3'b111, 1'b1, 5'd8, 3'(spp)}) begin
      failures++;
      $display("FAIL pre_reset: got sv=%b wb_en=%0b wb_reg=%0d cnt=%0d want 111/1/8/%0d",
               stage_valid, wb_en, wb_reg, stall_cnt, spp);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({stage_valid, wb_en, wb_reg, stall_cnt, stall_id, ex_fwd_a_sel, ex_fwd_b_sel} !== 17'd0) begin
      failures++;
      $display("FAIL async_reset: got sv=%b wb_en=%0b wb_reg=%0d cnt=%0d stall=%0b sels=%0d/%0d want 0",
               stage_valid, wb_en, wb_reg, stall_cnt, stall_id, ex_fwd_a_sel, ex_fwd_b_sel);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_raw();
    test_load_use();
    test_r0_priority();
    test_ext_stall_flush();
    test_saturation();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
